// File: rtl/passcode_sequencer_pkg.sv
// Shared types and constants for the passcode sequencer: FSM state encodings,
// pass/fail result codes and small width/saturation helpers.
package passcode_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_DECIDE  = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_e;

    localparam logic [1:0] PF_NONE = 2'b00;
    localparam logic [1:0] PF_PASS = 2'b01;
    localparam logic [1:0] PF_FAIL = 2'b10;

    // Bit-index width that stays legal for a single-bit code.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v, input logic [1:0] lim);
        return (v < lim) ? (v + 2'd1) : v;
    endfunction

endpackage

// File: rtl/passcode_sequencer_lockout_timer.sv
// Lockout duration timer: a Start_In pulse loads LOCKOUT_CYCLES and Expired_Out
// pulses during the last cycle of the window.
module passcode_sequencer_lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50000
) (
    input  logic Clock_In,
    input  logic Reset_n_In,
    input  logic Start_In,
    output logic Expired_Out
);

    localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;
    logic             expired_d;

    // Down-counter next state; a fresh start always reloads.
    always_comb begin
        cnt_d = cnt_q;
        if (Start_In) begin
            cnt_d = CNT_W'(LOCKOUT_CYCLES);
        end else if (cnt_q != CNT_W'(0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        expired_d = (cnt_d == CNT_W'(1));
    end

    // Counter and expiry registers.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            cnt_q     <= CNT_W'(0);
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign Expired_Out = expired_q;

endmodule

// File: rtl/passcode_sequencer.sv
// Serial passcode check for the unlock path: latches both codes, compares MSB
// first, reports pass/fail and tracks consecutive failures. PASSCODE_LOCKOUT_EN
// adds a timed lockout after MAX_ATTEMPTS consecutive failures.
module passcode_sequencer
    import passcode_sequencer_pkg::*;
#(
    parameter int CODE_BITS      = 16,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50000
) (
    input  logic                 Clock_In,
    input  logic                 Reset_n_In,
    input  logic                 Start_In,
    input  logic [CODE_BITS-1:0] Entered_Code_In,
    input  logic [CODE_BITS-1:0] Stored_Code_In,
    output logic                 Busy_Out,
    output logic                 LastBitFlag_Out,
    output logic                 MissMatch_Flag_Out,
    output logic [1:0]           Pass_Fail_Out,
    output logic                 Done_Out,
    output logic                 Locked_Out,
    output logic [1:0]           Attempts_Out
);

    localparam int         IDX_W   = idx_width(CODE_BITS);
    localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

    generate
        if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3) begin : g_bad_max_attempts
            $error("passcode_sequencer: MAX_ATTEMPTS must be in 1..3");
        end
        if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
            $error("passcode_sequencer: LOCKOUT_CYCLES must be >= 1");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CODE_BITS-1:0] ent_q, ent_d;
    logic [CODE_BITS-1:0] sto_q, sto_d;
    logic                 mm_q, mm_d;
    logic [1:0]           pf_q, pf_d;
    logic                 done_q, done_d;
    logic [1:0]           att_q, att_d;
    logic                 busy_q, busy_d;
    logic                 last_q, last_d;

`ifdef PASSCODE_LOCKOUT_EN
    logic timer_start_s;
    logic timer_expired_s;
    logic locked_q, locked_d;

    passcode_sequencer_lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .Clock_In    (Clock_In),
        .Reset_n_In  (Reset_n_In),
        .Start_In    (timer_start_s),
        .Expired_Out (timer_expired_s)
    );
`endif

    // Next-state and next-output logic for the check sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ent_d   = ent_q;
        sto_d   = sto_q;
        mm_d    = mm_q;
        pf_d    = pf_q;
        done_d  = 1'b0;
        att_d   = att_q;
`ifdef PASSCODE_LOCKOUT_EN
        timer_start_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start_In) begin
                    ent_d   = Entered_Code_In;
                    sto_d   = Stored_Code_In;
                    idx_d   = IDX_W'(CODE_BITS - 1);
                    mm_d    = 1'b0;
                    pf_d    = PF_NONE;
                    state_d = ST_COMPARE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                mm_d = mm_q | (ent_q[idx_q] ^ sto_q[idx_q]);
                if (idx_q == IDX_W'(0)) begin
                    state_d = ST_DECIDE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DECIDE: begin
                done_d = 1'b1;
                if (mm_q) begin
                    pf_d  = PF_FAIL;
                    att_d = sat_inc2(att_q, MAX_ATT);
`ifdef PASSCODE_LOCKOUT_EN
                    if (att_d == MAX_ATT) begin
                        state_d       = ST_LOCKOUT;
                        timer_start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    pf_d    = PF_PASS;
                    att_d   = 2'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
`ifdef PASSCODE_LOCKOUT_EN
                // Result stays FAIL across the lockout; only the count is cleared.
                if (timer_expired_s) begin
                    att_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        last_d = (state_d == ST_COMPARE) && (idx_d == IDX_W'(0));
`ifdef PASSCODE_LOCKOUT_EN
        locked_d = (state_d == ST_LOCKOUT);
`endif
    end

    // State and registered outputs; reset wins over any simultaneous request.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_W'(0);
            ent_q   <= {CODE_BITS{1'b0}};
            sto_q   <= {CODE_BITS{1'b0}};
            mm_q    <= 1'b0;
            pf_q    <= PF_NONE;
            done_q  <= 1'b0;
            att_q   <= 2'd0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ent_q   <= ent_d;
            sto_q   <= sto_d;
            mm_q    <= mm_d;
            pf_q    <= pf_d;
            done_q  <= done_d;
            att_q   <= att_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

`ifdef PASSCODE_LOCKOUT_EN
    // Lockout indicator register.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign Locked_Out = locked_q;
`else
    assign Locked_Out = 1'b0;
`endif

    assign Busy_Out           = busy_q;
    assign LastBitFlag_Out    = last_q;
    assign MissMatch_Flag_Out = mm_q;
    assign Pass_Fail_Out      = pf_q;
    assign Done_Out           = done_q;
    assign Attempts_Out       = att_q;

endmodule

// File: tb/tb_passcode_sequencer.sv
// Directed bench for passcode_sequencer (CODE_BITS=16, MAX_ATTEMPTS=3,
// LOCKOUT_CYCLES=20); lockout scenarios follow PASSCODE_LOCKOUT_EN.
module tb_passcode_sequencer;

    localparam int LOCK = 20;

    logic        clk_s = 1'b0;
    logic        rst_n_s;
    logic        start_s;
    logic [15:0] ent_s;
    logic [15:0] sto_s;
    logic        busy_s;
    logic        last_s;
    logic        mm_s;
    logic [1:0]  pf_s;
    logic        done_s;
    logic        locked_s;
    logic [1:0]  att_s;

    int checks_cnt = 0;
    int errors_cnt = 0;

    passcode_sequencer #(
        .CODE_BITS      (16),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .Clock_In           (clk_s),
        .Reset_n_In         (rst_n_s),
        .Start_In           (start_s),
        .Entered_Code_In    (ent_s),
        .Stored_Code_In     (sto_s),
        .Busy_Out           (busy_s),
        .LastBitFlag_Out    (last_s),
        .MissMatch_Flag_Out (mm_s),
        .Pass_Fail_Out      (pf_s),
        .Done_Out           (done_s),
        .Locked_Out         (locked_s),
        .Attempts_Out       (att_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_s), 32'd0);
        check_eq({tag, "_last"}, 32'(last_s), 32'd0);
        check_eq({tag, "_mm"}, 32'(mm_s), 32'd0);
        check_eq({tag, "_pf"}, 32'(pf_s), 32'd0);
        check_eq({tag, "_done"}, 32'(done_s), 32'd0);
        check_eq({tag, "_locked"}, 32'(locked_s), 32'd0);
        check_eq({tag, "_att"}, 32'(att_s), 32'd0);
    endtask

    // Full check from Start to Done; ends in the cycle Done is high.
    task automatic run_check(input string tag,
                             input logic [15:0] ent, input logic [15:0] sto,
                             input logic [15:0] ent_late, input logic [15:0] sto_late,
                             input logic hold_start,
                             input logic [1:0] exp_pf, input logic [1:0] exp_att);
        logic [15:0] diff;
        logic        exp_mm;
        diff    = ent ^ sto;
        exp_mm  = 1'b0;
        ent_s   = ent;
        sto_s   = sto;
        start_s = 1'b1;
        tick();
        if (!hold_start) start_s = 1'b0;
        ent_s = ent_late;
        sto_s = sto_late;
        check_eq({tag, "_busy0"}, 32'(busy_s), 32'd1);
        check_eq({tag, "_pf0"}, 32'(pf_s), 32'd0);
        check_eq({tag, "_mm0"}, 32'(mm_s), 32'd0);
        for (int j = 1; j <= 16; j++) begin
            tick();
            exp_mm = exp_mm | diff[16-j];
            check_eq($sformatf("%s_mm%0d", tag, j), 32'(mm_s), 32'(exp_mm));
            check_eq($sformatf("%s_last%0d", tag, j), 32'(last_s), 32'(j == 15));
            check_eq($sformatf("%s_done%0d", tag, j), 32'(done_s), 32'd0);
        end
        check_eq({tag, "_busy_decide"}, 32'(busy_s), 32'd1);
        start_s = 1'b0;
        tick();
        check_eq({tag, "_done"}, 32'(done_s), 32'd1);
        check_eq({tag, "_pf"}, 32'(pf_s), 32'(exp_pf));
        check_eq({tag, "_att"}, 32'(att_s), 32'(exp_att));
        check_eq({tag, "_mm_hold"}, 32'(mm_s), 32'(exp_mm));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_s = 1'b0;
        start_s = 1'b0;
        ent_s   = 16'h0000;
        sto_s   = 16'h0000;
        tick();
        tick();
        check_all_zero("reset");
        rst_n_s = 1'b1;
        tick();
        check_all_zero("idle");

        // 1: matching codes
        run_check("t1", 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0, 2'b01, 2'd0);
        tick();
        check_eq("t1_done_pulse", 32'(done_s), 32'd0);
        check_eq("t1_pf_hold", 32'(pf_s), 32'd1);
        check_eq("t1_busy_end", 32'(busy_s), 32'd0);

        // 2: LSB differs; 3: MSB differs
        run_check("t2", 16'h1235, 16'h1234, 16'h1235, 16'h1234, 1'b0, 2'b10, 2'd1);
        tick();
        run_check("t3", 16'h9234, 16'h1234, 16'h9234, 16'h1234, 1'b0, 2'b10, 2'd2);
        tick();

`ifdef PASSCODE_LOCKOUT_EN
        // 4: third consecutive fail enters lockout for LOCK cycles
        run_check("t4", 16'h0F0F, 16'h0F0E, 16'h0F0F, 16'h0F0E, 1'b0, 2'b10, 2'd3);
        check_eq("t4_locked0", 32'(locked_s), 32'd1);
        check_eq("t4_busy0", 32'(busy_s), 32'd1);
        ent_s = 16'h5555;
        sto_s = 16'h5555;
        for (int c = 1; c < LOCK; c++) begin
            start_s = (c == 5);
            tick();
            check_eq($sformatf("t4_locked%0d", c), 32'(locked_s), 32'd1);
            check_eq($sformatf("t4_pf%0d", c), 32'(pf_s), 32'd2);
        end
        start_s = 1'b0;
        tick();
        check_eq("t4_unlocked", 32'(locked_s), 32'd0);
        check_eq("t4_att_clr", 32'(att_s), 32'd0);
        check_eq("t4_busy_exit", 32'(busy_s), 32'd0);
        check_eq("t4_pf_exit", 32'(pf_s), 32'd2);
        tick();
        check_eq("t4_no_queue", 32'(busy_s), 32'd0);
        run_check("t4_pass", 16'h5555, 16'h5555, 16'h5555, 16'h5555, 1'b0, 2'b01, 2'd0);
        tick();
`else
        // 4: without lockout the count saturates and the block stays usable
        run_check("t4", 16'h0F0F, 16'h0F0E, 16'h0F0F, 16'h0F0E, 1'b0, 2'b10, 2'd3);
        check_eq("t4_locked", 32'(locked_s), 32'd0);
        check_eq("t4_busy", 32'(busy_s), 32'd0);
        tick();
        run_check("t4_sat", 16'hF000, 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b10, 2'd3);
        tick();
        run_check("t4_pass", 16'h5555, 16'h5555, 16'h5555, 16'h5555, 1'b0, 2'b01, 2'd0);
        tick();
`endif

        // 5: Start held and inputs changed after latch
        run_check("t5", 16'hABCD, 16'hABCD, 16'h0000, 16'hFFFF, 1'b1, 2'b01, 2'd0);
        tick();
        check_eq("t5_single_busy", 32'(busy_s), 32'd0);
        check_eq("t5_single_done", 32'(done_s), 32'd0);

        // 6: reset mid-compare
        run_check("t6_pre", 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 2'b10, 2'd1);
        tick();
        ent_s   = 16'h9234;
        sto_s   = 16'h1234;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check_eq("t6_mm_before", 32'(mm_s), 32'd1);
        rst_n_s = 1'b0;
        tick();
        check_all_zero("t6_rst_cmp");
        rst_n_s = 1'b1;
        tick();
        check_eq("t6_idle", 32'(busy_s), 32'd0);
        run_check("t6_fresh", 16'h4321, 16'h4321, 16'h4321, 16'h4321, 1'b0, 2'b01, 2'd0);
        tick();

`ifdef PASSCODE_LOCKOUT_EN
        // 6b: reset mid-lockout
        run_check("t6_f1", 16'h0002, 16'h0000, 16'h0002, 16'h0000, 1'b0, 2'b10, 2'd1);
        tick();
        run_check("t6_f2", 16'h0004, 16'h0000, 16'h0004, 16'h0000, 1'b0, 2'b10, 2'd2);
        tick();
        run_check("t6_f3", 16'h0008, 16'h0000, 16'h0008, 16'h0000, 1'b0, 2'b10, 2'd3);
        for (int c = 0; c < 5; c++) tick();
        check_eq("t6_locked_mid", 32'(locked_s), 32'd1);
        rst_n_s = 1'b0;
        tick();
        check_all_zero("t6_rst_lock");
        rst_n_s = 1'b1;
        run_check("t6_after_lock", 16'h7777, 16'h7777, 16'h7777, 16'h7777, 1'b0, 2'b01, 2'd0);
        tick();
`endif

        // Reset and Start together: reset wins
        rst_n_s = 1'b0;
        start_s = 1'b1;
        tick();
        check_all_zero("rst_vs_start");
        start_s = 1'b0;
        rst_n_s = 1'b1;
        tick();
        check_eq("rst_vs_start_idle", 32'(busy_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
